pipeline_mem_arbiter: RTL and testbench
=======================================

# pipeline_mem_arbiter

Arbitrates the single physical-memory port of the pipelined LC-3b datapath between the instruction-fetch path and the MEM-stage data path. Both requesters see a private burst-wide read/write port with their own response strobe. The block owns the downstream port exclusively and runs one transaction at a time. Data requests have priority, and a bounded-streak rule guarantees instruction fetches are not starved.

## Interface
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch waits; range 1–15.
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read  in  1  instruction-fetch read request (level).
- i_address  in  16 (lc3b_word)  fetch address.
- i_resp  out  1  fetch completion strobe.
- i_rdata  out  128 (lc3b_burst)  fetched line.
- d_read  in  1  data read request (level).
- d_write  in  1  data write request (level).
- d_address  in  16 (lc3b_word)  data address.
- d_wdata  in  128 (lc3b_burst)  write line.
- d_resp  out  1  data completion strobe.
- d_rdata  out  128 (lc3b_burst)  read line.
- mem_read  out  1  downstream read.
- mem_write  out  1  downstream write.
- mem_address  out  16 (lc3b_word)  downstream address.
- mem_wdata  out  128 (lc3b_burst)  downstream write line.
- mem_resp  in  1  downstream completion.
- mem_rdata  in  128 (lc3b_burst)  downstream read line.

## Operation
- FSM states: IDLE, IFETCH, DATA_RD, DATA_WR.
- IDLE is the only state in which arbitration happens. The decision is evaluated every cycle from the live request inputs.
- Decision rules, in order:
  - If (d_read|d_write) and not (i_read && streak==MAX_DATA_STREAK), take the data path. d_write wins over d_read, so the next state is DATA_WR, otherwise DATA_RD.
  - Else if i_read, go to IFETCH.
  - Else stay in IDLE.
- On the grant edge, latch into output registers:
  - mem_address from the granted requester's address.
  - mem_wdata from d_wdata, for DATA_WR only.
  - mem_read/mem_write per the granted state.
- Request inputs are ignored outside IDLE. Address or data changes, or request withdrawal, mid-transaction have no effect, and the downstream transaction always completes.
- In a busy state, a cycle with mem_resp=1 does the following:
  - Pulses the owner's resp for that same cycle (combinational: i_resp = mem_resp & state==IFETCH; d_resp = mem_resp & state∈{DATA_RD,DATA_WR}).
  - Clears mem_read/mem_write at the edge and returns the FSM to IDLE.
- i_rdata and d_rdata pass mem_rdata through unconditionally. Their contents are valid only while the matching resp is high.
- mem_resp in IDLE is ignored and produces no resp pulse.
- Streak counter (4 bits) updates only at grant edges:
  - Data grant with i_read=1: streak+1, saturating at MAX_DATA_STREAK.
  - Data grant with i_read=0: reset to 0.
  - IFETCH grant: reset to 0.

## Timing
- Reset values:
  - FSM is IDLE and streak is 0.
  - mem_read, mem_write, mem_address and mem_wdata are 0.
  - i_resp and d_resp are 0.
- Reset asserted mid-transaction: outputs clear immediately (asynchronously). A later mem_resp is ignored and no resp is issued. Requesters must re-issue.
- Latency: a request seen in IDLE at edge N drives mem_read/mem_write from N+1. The response strobe coincides with mem_resp. Total latency is the downstream latency + 1 cycle.
- The cycle after a resp is always an IDLE decision cycle, so back-to-back transactions are separated by at least one dead cycle.
- Handshake rule for requesters: after sampling resp=1, a requester drops its request by the next cycle unless it wants a new transaction. A stale request held one cycle longer is treated as a new request.
- mem_read and mem_write are never both 1. All downstream outputs are registered and glitch-free.

## Structure
- The following go in the shared lc3b_types package alongside lc3b_word and lc3b_burst:
  - The state enum lc3b_arb_state_t {IDLE, IFETCH, DATA_RD, DATA_WR}.
  - The streak-width constant.
- The block is a single module with no sub-module; the FSM and the streak counter share the grant decision.

## Test plan
- Single fetch: i_read=1, i_address=0x1230, with mem_resp 3 cycles after mem_read rises and mem_rdata=0xA5…A5. Required: mem_address=0x1230, i_resp for one cycle, i_rdata=0xA5…A5, and d_resp stays 0.
- Simultaneous requests: i_read=1 and d_read=1 at address 0x4000 in the same cycle. Required: DATA_RD first at 0x4000, then IFETCH after d_resp plus one IDLE cycle.
- Write priority: d_read=1 and d_write=1 with d_wdata=0x…BEEF. Required: mem_write=1, mem_read=0, mem_wdata=0x…BEEF.
- Starvation bound: with MAX_DATA_STREAK=4, hold i_read=1 and issue continuous data requests. Required: exactly 4 data grants, then one IFETCH, then the data grants resume.
- Reset mid-transaction: assert reset_n=0 two cycles into DATA_WR, release it, then pulse mem_resp. Required: mem_write drops asynchronously, no d_resp is issued, and the FSM is in IDLE.
- Request withdrawal: drop i_read and change i_address the cycle after the grant. Required: mem_address holds the latched value and i_resp still pulses on mem_resp.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: word/burst widths plus the memory arbiter's state and streak types.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;

    // Width of the arbiter's consecutive-data-grant counter; bounds MAX_DATA_STREAK to 15.
    localparam int unsigned ARB_STREAK_W = 4;
    typedef logic [ARB_STREAK_W-1:0] lc3b_arb_streak_t;

    typedef enum logic [1:0] {
        IDLE,
        IFETCH,
        DATA_RD,
        DATA_WR
    } lc3b_arb_state_t;

endpackage

// File: rtl/pipeline_mem_arbiter.sv
// Shares one physical memory port between instruction fetch and MEM-stage data, one transaction at a time.
// Latency: request seen in IDLE at edge N drives mem_* from N+1; resp strobes coincide with mem_resp.
// Backpressure: requesters hold a level request until their resp; data wins unless a fetch has waited MAX_DATA_STREAK grants.
module pipeline_mem_arbiter
    import lc3b_types::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic      clk,
    input  logic      reset_n,

    input  logic      i_read,
    input  lc3b_word  i_address,
    output logic      i_resp,
    output lc3b_burst i_rdata,

    input  logic      d_read,
    input  logic      d_write,
    input  lc3b_word  d_address,
    input  lc3b_burst d_wdata,
    output logic      d_resp,
    output lc3b_burst d_rdata,

    output logic      mem_read,
    output logic      mem_write,
    output lc3b_word  mem_address,
    output lc3b_burst mem_wdata,
    input  logic      mem_resp,
    input  lc3b_burst mem_rdata
);

    localparam lc3b_arb_streak_t STREAK_MAX = lc3b_arb_streak_t'(MAX_DATA_STREAK);

    lc3b_arb_state_t  state;
    lc3b_arb_state_t  state_next;
    lc3b_arb_streak_t streak;
    lc3b_arb_streak_t streak_next;
    logic             data_req;
    logic             fetch_starved;

    // Grant decision in IDLE (shared by FSM and streak counter); busy states wait for mem_resp.
    always_comb begin
        state_next    = state;
        streak_next   = streak;
        data_req      = d_read | d_write;
        fetch_starved = i_read && (streak == STREAK_MAX);
        case (state)
            IDLE: begin
                if (data_req && !fetch_starved) begin
                    state_next = d_write ? DATA_WR : DATA_RD;
                    if (!i_read) begin
                        streak_next = '0;
                    end else if (streak != STREAK_MAX) begin
                        streak_next = streak + 1'b1;
                    end
                end else if (i_read) begin
                    state_next  = IFETCH;
                    streak_next = '0;
                end
            end
            default: begin
                if (mem_resp) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // State, streak and registered downstream command; captured only on the grant edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            streak      <= '0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else begin
            state  <= state_next;
            streak <= streak_next;
            if (state == IDLE) begin
                case (state_next)
                    IFETCH: begin
                        mem_address <= i_address;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                    end
                    DATA_RD: begin
                        mem_address <= d_address;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
                    end
                    DATA_WR: begin
                        mem_address <= d_address;
                        mem_wdata   <= d_wdata;
                        mem_read    <= 1'b0;
                        mem_write   <= 1'b1;
                    end
                    default: begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                endcase
            end else if (mem_resp) begin
                mem_read  <= 1'b0;
                mem_write <= 1'b0;
            end
        end
    end

    // Response strobes follow mem_resp in the owning state; read data is a plain pass-through.
    always_comb begin
        i_resp  = mem_resp && (state == IFETCH);
        d_resp  = mem_resp && ((state == DATA_RD) || (state == DATA_WR));
        i_rdata = mem_rdata;
        d_rdata = mem_rdata;
    end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
module tb_pipeline_mem_arbiter;
    import lc3b_types::*;

    logic      clk = 1'b0;
    logic      reset_n;
    logic      i_read;
    lc3b_word  i_address;
    logic      i_resp;
    lc3b_burst i_rdata;
    logic      d_read;
    logic      d_write;
    lc3b_word  d_address;
    lc3b_burst d_wdata;
    logic      d_resp;
    lc3b_burst d_rdata;
    logic      mem_read;
    logic      mem_write;
    lc3b_word  mem_address;
    lc3b_burst mem_wdata;
    logic      mem_resp;
    lc3b_burst mem_rdata;

    always #5 clk = ~clk;

    pipeline_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    int applied = 0;
    int miscompares = 0;
    int cyc = 0;
    int grant_cnt = 0;
    int resp_cnt = 0;
    int last_grant_cyc = 0;
    int last_dresp_cyc = 0;
    logic auto_resp = 1'b1;
    int   lat_cfg = 1;

    typedef struct { logic rd; logic wr; lc3b_word addr; lc3b_burst wdata; } grant_t;
    typedef struct { logic is_data; lc3b_burst rdata; } resp_t;
    // kind: 0 fetch, 1 data read, 2 data write, 3 data read+write
    typedef struct { int kind; lc3b_word addr; lc3b_burst wdata; int lat;
                     logic exp_rd; logic exp_wr; logic exp_data; } vec_t;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];

    // Memory contents seen by the bench: address 0x1230 reads back all 0xA5.
    function automatic lc3b_burst mem_model(input lc3b_word a);
        lc3b_burst b;
        b = {16{8'hA5}};
        b[15:0] = b[15:0] ^ a ^ 16'h1230;
        return b;
    endfunction

    task automatic check(input string name, input lc3b_burst act, input lc3b_burst exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, wanted %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        applied++;
        miscompares++;
        $display("FAIL %s: got timeout, wanted event", name);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream memory: answers lat_cfg cycles after the command rises.
    initial begin : responder
        int cnt;
        cnt = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (auto_resp) begin
                if (mem_resp) begin
                    mem_resp = 1'b0;
                    cnt = 0;
                end else if (mem_read || mem_write) begin
                    if (cnt >= lat_cfg) begin
                        mem_resp  = 1'b1;
                        mem_rdata = mem_model(mem_address);
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Scoreboard monitor: pops expected grants/responses as the DUT produces them.
    initial begin : monitor
        logic   busy_prev;
        grant_t g;
        resp_t  r;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            check("rd_wr_exclusive", 128'(mem_read & mem_write), '0);
            check("resp_exclusive", 128'(i_resp & d_resp), '0);
            if ((mem_read || mem_write) && !busy_prev) begin
                grant_cnt++;
                last_grant_cyc = cyc;
                if (exp_grant.size() == 0) begin
                    timeout("unexpected_grant");
                end else begin
                    g = exp_grant.pop_front();
                    check("grant_addr", 128'(mem_address), 128'(g.addr));
                    check("grant_read", 128'(mem_read), 128'(g.rd));
                    check("grant_write", 128'(mem_write), 128'(g.wr));
                    if (g.wr) check("grant_wdata", mem_wdata, g.wdata);
                end
            end
            if (i_resp || d_resp) begin
                resp_cnt++;
                if (d_resp) last_dresp_cyc = cyc;
                if (exp_resp.size() == 0) begin
                    timeout("unexpected_resp");
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_is_data", 128'(d_resp), 128'(r.is_data));
                    check("resp_rdata", r.is_data ? d_rdata : i_rdata, r.rdata);
                end
            end
            busy_prev = mem_read || mem_write;
        end
    end

    task automatic wait_grant(input int target);
        bit got;
        got = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(posedge clk);
            #1;
            if (grant_cnt >= target) got = 1;
        end
        if (!got) timeout("wait_grant");
    endtask

    task automatic wait_resp(input int target);
        bit got;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk);
            #1;
            if (resp_cnt >= target) got = 1;
        end
        if (!got) timeout("wait_resp");
    endtask

    task automatic run_vec(input vec_t v);
        int g0;
        int r0;
        lat_cfg = v.lat;
        @(posedge clk);
        #1;
        g0 = grant_cnt;
        r0 = resp_cnt;
        exp_grant.push_back('{v.exp_rd, v.exp_wr, v.addr, v.wdata});
        exp_resp.push_back('{v.exp_data, mem_model(v.addr)});
        d_address = v.addr;
        i_address = v.addr;
        d_wdata   = v.wdata;
        case (v.kind)
            0: i_read = 1'b1;
            1: d_read = 1'b1;
            2: d_write = 1'b1;
            default: begin d_read = 1'b1; d_write = 1'b1; end
        endcase
        wait_grant(g0 + 1);
        // Withdraw and scramble inputs mid-transaction; the latched command must hold.
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = ~v.addr; d_address = ~v.addr; d_wdata = ~v.wdata;
        @(negedge clk);
        check("hold_addr", 128'(mem_address), 128'(v.addr));
        if (v.exp_wr) check("hold_wdata", mem_wdata, v.wdata);
        wait_resp(r0 + 1);
    endtask

    vec_t vecs[6];

    initial begin
        int g0;
        int r0;
        vecs[0] = '{0, 16'h1230, '0, 3, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1, 16'h4444, '0, 1, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{2, 16'h5550, {4{32'h1357_9BDF}}, 2, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{3, 16'h6000, {112'h0, 16'hBEEF}, 0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{0, 16'hFFFF, '0, 5, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{2, 16'h0000, {128{1'b1}}, 1, 1'b0, 1'b1, 1'b1};

        reset_n = 1'b0;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        #12;
        check("rst_mem_read", 128'(mem_read), '0);
        check("rst_mem_write", 128'(mem_write), '0);
        check("rst_mem_address", 128'(mem_address), '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_resps", 128'({i_resp, d_resp}), '0);
        check("rst_state", 128'(dut.state), 128'(IDLE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Simultaneous fetch and data read: data first, then fetch after one dead cycle.
        lat_cfg = 1;
        @(posedge clk);
        #1;
        g0 = grant_cnt;
        r0 = resp_cnt;
        exp_grant.push_back('{1'b1, 1'b0, 16'h4000, '0});
        exp_grant.push_back('{1'b1, 1'b0, 16'h0800, '0});
        exp_resp.push_back('{1'b1, mem_model(16'h4000)});
        exp_resp.push_back('{1'b0, mem_model(16'h0800)});
        i_read = 1'b1; i_address = 16'h0800;
        d_read = 1'b1; d_address = 16'h4000;
        wait_grant(g0 + 1);
        d_read = 1'b0;
        wait_grant(g0 + 2);
        i_read = 1'b0;
        check("dead_cycle_gap", 128'(last_grant_cyc - last_dresp_cyc), 128'(2));
        wait_resp(r0 + 2);

        // Starvation bound: four data grants, one fetch, then data again.
        lat_cfg = 2;
        @(posedge clk);
        #1;
        g0 = grant_cnt;
        r0 = resp_cnt;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) begin
                exp_grant.push_back('{1'b1, 1'b0, 16'h0F00, '0});
                exp_resp.push_back('{1'b0, mem_model(16'h0F00)});
            end else begin
                exp_grant.push_back('{1'b1, 1'b0, 16'h2000, '0});
                exp_resp.push_back('{1'b1, mem_model(16'h2000)});
            end
        end
        i_read = 1'b1; i_address = 16'h0F00;
        d_read = 1'b1; d_address = 16'h2000;
        wait_grant(g0 + 7);
        i_read = 1'b0; d_read = 1'b0;
        wait_resp(r0 + 7);

        // Reset two cycles into a write, then a stray mem_resp must be ignored.
        auto_resp = 1'b0;
        @(posedge clk);
        #1;
        g0 = grant_cnt;
        exp_grant.push_back('{1'b0, 1'b1, 16'h7000, {4{32'hCAFE_F00D}}});
        d_write = 1'b1; d_address = 16'h7000; d_wdata = {4{32'hCAFE_F00D}};
        wait_grant(g0 + 1);
        d_write = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_mem_write", 128'(mem_write), '0);
        check("async_mem_address", 128'(mem_address), '0);
        check("async_state", 128'(dut.state), 128'(IDLE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = mem_model(16'h7000);
        #1;
        check("stray_d_resp", 128'(d_resp), '0);
        check("stray_i_resp", 128'(i_resp), '0);
        @(posedge clk);
        #1;
        mem_resp = 1'b0;
        check("post_reset_state", 128'(dut.state), 128'(IDLE));
        check("post_reset_cmd", 128'({mem_read, mem_write}), '0);
        auto_resp = 1'b1;

        // Normal traffic resumes after the aborted write.
        run_vec(vecs[1]);

        check("grant_queue_drained", 128'(exp_grant.size()), '0);
        check("resp_queue_drained", 128'(exp_resp.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
